decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 98 +++++++++
 tb/tb_decode_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// Decode stage: 32x32 register file, pending-writer scoreboard, hazard stall
// and a single registered issue slot toward execute.
module decode_stage #(
  parameter int WB_BYPASS = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        ex_valid,
  output logic [4:0]  ex_opcode,
  output logic [4:0]  ex_rd,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [31:0] ex_imm,
  output logic [31:0] ex_pc
);
  localparam logic [4:0] OP_BEQ = 5'd14;
  localparam logic [4:0] OP_J   = 5'd16;
  localparam logic [4:0] OP_NOP = 5'd31;

  logic [31:0] rf [32];
  logic [31:0] pending;

  logic [4:0]  opcode, rd, rs, rt, bsrc;
  logic [16:0] imm;
  logic        use_a, use_b, writer, hazard, issue;
  logic [31:0] wb_mask, byp_mask, eff_pend, set_mask, a_val, b_val;

  assign opcode = instr_in[31:27];
  assign rd     = instr_in[26:22];
  assign rs     = instr_in[21:17];
  assign rt     = instr_in[16:12];
  assign imm    = instr_in[16:0];

  // An all-ones word decodes to opcode 31, so it falls out as a NOP here.
  assign use_a  = (opcode != OP_J) && (opcode != OP_NOP);
  assign use_b  = (opcode == 5'd0) || (opcode == 5'd1) || (opcode == 5'd3) ||
                  (opcode == 5'd4) || (opcode == 5'd17) || (opcode == OP_BEQ);
  assign bsrc   = (opcode == OP_BEQ) ? rd : rt;
  assign writer = (opcode != OP_BEQ) && (opcode != OP_J) && (opcode != OP_NOP) &&
                  (rd != 5'd0);

  assign wb_mask  = wb_en ? (32'd1 << wb_addr) : 32'd0;
  assign byp_mask = (WB_BYPASS != 0) ? wb_mask : 32'd0;
  assign eff_pend = pending & ~byp_mask;

  assign hazard = in_valid && ((use_a && eff_pend[rs]) || (use_b && eff_pend[bsrc]) ||
                               (writer && eff_pend[rd]));
  assign in_ready = !(hazard && !flush);
  assign issue    = in_valid && in_ready && !flush;
  assign set_mask = (issue && writer) ? (32'd1 << rd) : 32'd0;

  function automatic logic [31:0] rd_port(input logic [4:0] r);
    if (r == 5'd0)                                      return 32'd0;
    else if ((WB_BYPASS != 0) && wb_en && wb_addr == r) return wb_data;
    else                                                return rf[r];
  endfunction

  assign a_val = use_a ? rd_port(rs)   : 32'd0;
  assign b_val = use_b ? rd_port(bsrc) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= 32'd0;
      pending   <= 32'd0;
      ex_valid  <= 1'b0;
      ex_opcode <= OP_NOP;
      ex_rd     <= 5'd0;
      ex_a      <= 32'd0;
      ex_b      <= 32'd0;
      ex_imm    <= 32'd0;
      ex_pc     <= 32'd0;
    end else begin
      if (wb_en && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
      // set after clear so a same-cycle issue to Rr keeps it pending
      pending <= ((pending & ~wb_mask) | set_mask) & ~32'd1;
      if (issue) begin
        ex_valid  <= 1'b1;
        ex_opcode <= opcode;
        ex_rd     <= rd;
        ex_a      <= a_val;
        ex_b      <= b_val;
        ex_imm    <= {{15{imm[16]}}, imm};
        ex_pc     <= pc_in;
      end else begin
        ex_valid  <= 1'b0;
        ex_opcode <= OP_NOP;
      end
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// Randomized + directed bench for decode_stage against a per-register
// behavioural model (register values and outstanding-writer flags).
module tb_decode_stage;
  localparam int WB_BYPASS = 1;

  logic        clk = 1'b0;
  logic        rst, in_valid, flush, wb_en, in_ready, ex_valid;
  logic [31:0] instr_in, pc_in, wb_data, ex_a, ex_b, ex_imm, ex_pc;
  logic [4:0]  wb_addr, ex_opcode, ex_rd;

  int checks = 0, failures = 0;
  logic [31:0] m_rf [32];
  bit          m_busy [32];
  logic        obs_rdy;

  always #5 clk = ~clk;

  decode_stage #(.WB_BYPASS(WB_BYPASS)) dut (
    .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm), .ex_pc(ex_pc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit bypassed(input int r);
    return WB_BYPASS != 0 && wb_en && int'(wb_addr) == r;
  endfunction

  function automatic logic [31:0] mread(input int r);
    if (r == 0) return 0;
    if (bypassed(r)) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic [31:0] mk(input int op, input int d, input int s, input int t,
                                     input int im);
    logic [31:0] w;
    w = (op << 27) | (d << 22) | (s << 17);
    if (t >= 0) w = w | (t << 12);
    else        w = w | (im & 32'h1FFFF);
    return w;
  endfunction

  // One clock: drive, check in_ready, clock, check ex_*, advance the model.
  task automatic cyc(input logic r, input logic iv, input logic fl, input logic [31:0] ins,
                     input logic [31:0] pc, input logic we, input logic [4:0] wa,
                     input logic [31:0] wd);
    int op, d, s, t, bs;
    bit ua, ub, wr, haz, rdy, iss;
    logic [31:0] ea, eb, eimm;
    rst = r; in_valid = iv; flush = fl; instr_in = ins; pc_in = pc;
    wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    op = int'(ins[31:27]); d = int'(ins[26:22]); s = int'(ins[21:17]); t = int'(ins[16:12]);
    ua = !(op == 16 || op == 31);
    ub = op inside {0, 1, 3, 4, 17, 14};
    bs = (op == 14) ? d : t;
    wr = !(op inside {14, 16, 31}) && d != 0;
    haz = iv && ((ua && m_busy[s] && !bypassed(s)) || (ub && m_busy[bs] && !bypassed(bs)) ||
                 (wr && m_busy[d] && !bypassed(d)));
    rdy = !(haz && !fl);
    iss = iv && rdy && !fl;
    ea = mread(s); eb = mread(bs);
    eimm = ins[16] ? (32'(ins[16:0]) + 32'hFFFE0000) : 32'(ins[16:0]);
    obs_rdy = in_ready;
    if (!r) chk("in_ready", 32'(in_ready), 32'(rdy));
    @(posedge clk); #1;
    if (r) begin
      chk("rst_valid", 32'(ex_valid), 0); chk("rst_op", 32'(ex_opcode), 31);
      chk("rst_rd", 32'(ex_rd), 0); chk("rst_a", ex_a, 0); chk("rst_b", ex_b, 0);
      chk("rst_imm", ex_imm, 0); chk("rst_pc", ex_pc, 0);
      for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_busy[i] = 0; end
    end else begin
      chk("ex_valid", 32'(ex_valid), 32'(iss));
      if (iss) begin
        chk("ex_opcode", 32'(ex_opcode), 32'(op));
        chk("ex_rd", 32'(ex_rd), 32'(d));
        chk("ex_imm", ex_imm, eimm);
        chk("ex_pc", ex_pc, pc);
        if (ua) chk("ex_a", ex_a, ea);
        if (ub) chk("ex_b", ex_b, eb);
      end else chk("bubble_op", 32'(ex_opcode), 31);
      if (we) m_busy[wa] = 0;
      if (iss && wr) m_busy[d] = 1;
      if (we && wa != 0) m_rf[wa] = wd;
      m_busy[0] = 0;
    end
  endtask

  initial begin
    int ops [10] = '{0, 1, 2, 3, 4, 14, 16, 17, 31, 9};
    logic [31:0] ins;
    int wa;
    for (int i = 0; i < 32; i++) begin m_rf[i] = 0; m_busy[i] = 0; end

    cyc(1, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 1, 32'h10420001, 7, 1, 3, 9);
    // first cycle after reset: nothing pending, ADDI R1,R1,1 at pc 1
    cyc(0, 1, 0, 32'h10420001, 1, 0, 0, 0);
    chk("rdy_after_rst", 32'(obs_rdy), 1);
    chk("addi_valid", 32'(ex_valid), 1); chk("addi_op", 32'(ex_opcode), 2);
    chk("addi_rd", 32'(ex_rd), 1); chk("addi_a", ex_a, 0);
    chk("addi_imm", ex_imm, 1); chk("addi_pc", ex_pc, 1);
    // MLT R3,R1,R2 stalls on R1 until its writeback is bypassed
    cyc(0, 1, 0, 32'h20C22000, 2, 0, 0, 0);
    chk("mlt_stall", 32'(obs_rdy), 0); chk("mlt_bubble", 32'(ex_valid), 0);
    cyc(0, 1, 0, 32'h20C22000, 2, 0, 0, 0);
    chk("mlt_stall2", 32'(obs_rdy), 0);
    cyc(0, 1, 0, 32'h20C22000, 2, 1, 1, 5);
    chk("mlt_issue", 32'(ex_valid), 1); chk("mlt_a", ex_a, 5);
    // immediate sign extension boundaries
    cyc(0, 1, 0, mk(2, 5, 0, -1, 32'h1FFFF), 3, 0, 0, 0);
    chk("imm_neg", ex_imm, 32'hFFFFFFFF);
    cyc(0, 1, 0, mk(2, 6, 0, -1, 32'h0FFFF), 4, 0, 0, 0);
    chk("imm_pos", ex_imm, 32'h0000FFFF);
    // flushed hazarded CMP R4,R2,R1 must not mark R4
    cyc(0, 1, 0, mk(2, 2, 0, -1, 1), 5, 0, 0, 0);
    cyc(0, 1, 1, mk(3, 4, 2, 1, 0), 6, 0, 0, 0);
    chk("flush_rdy", 32'(obs_rdy), 1); chk("flush_valid", 32'(ex_valid), 0);
    cyc(0, 1, 0, mk(2, 7, 4, -1, 0), 7, 0, 0, 0);
    chk("r4_clear", 32'(obs_rdy), 1);
    // R0 is hardwired to zero even when written
    cyc(0, 1, 0, mk(2, 8, 0, -1, 0), 8, 1, 0, 32'hDEAD);
    chk("r0_byp", ex_a, 0);
    cyc(0, 1, 0, mk(2, 8, 0, -1, 0), 9, 0, 0, 0);
    chk("r0_read", ex_a, 0);
    // reset with R1 pending and an issue/writeback in the same cycle
    cyc(0, 1, 0, 32'h10420001, 10, 0, 0, 0);
    cyc(1, 1, 0, mk(2, 9, 1, -1, 0), 11, 1, 9, 32'h55);
    cyc(0, 1, 0, mk(2, 9, 1, -1, 0), 12, 0, 0, 0);
    chk("rst_pend_clr", 32'(obs_rdy), 1);

    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(9) == 0) ins = 32'hFFFFFFFF;
      else ins = mk(ops[$urandom_range(9)], $urandom_range(3), $urandom_range(3),
                    $urandom_range(3), 0) | ($urandom & 32'h0FFF);
      wa = $urandom_range(4);
      cyc($urandom_range(99) == 0, $urandom_range(4) != 0, $urandom_range(9) == 0, ins,
          $urandom, $urandom_range(1) == 1, 5'(wa), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
